// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: hazard controls in, instruction memory port, and the
// IF/ID register outputs plus status toward the decoder.
interface instr_fetch_if;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        misalign_fault;
    logic        range_fault;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        input  stall, flush, redirect_valid, redirect_target, imem_data,
        output imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
               misalign_fault, range_fault, halted, fetch_count
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_target, imem_data,
        input  imem_addr, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus4,
               misalign_fault, range_fault, halted, fetch_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter and IF/ID pipeline register in front of a single-cycle
// instruction memory, with stall/flush/redirect handling and sticky faults.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 512,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    instr_fetch_if.master   bus
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

    localparam logic [31:0] LAST_FETCH = 32'(IMEM_BYTES - 4);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        misalign_q, misalign_d;
    logic        range_q, range_d;
    logic        halted_q, halted_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;
    logic        redirect_misaligned;

    assign pc_plus4            = pc_q + 32'd4;
    assign redirect_pc         = {bus.redirect_target[31:2], 2'b00};
    assign redirect_misaligned = (bus.redirect_target[1:0] != 2'b00);

    always_comb begin
        // NOTE: every _d takes its held value first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        misalign_d = misalign_q;
        range_d    = range_q;
        count_d    = count_q;

        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.redirect_valid) begin
                    pc_d       = redirect_pc;
                    misalign_d = misalign_q | redirect_misaligned;
                    valid_d    = 1'b0;
                    instr_d    = NOP_INSTR;
                end else if (bus.flush) begin
                    pc_d    = pc_plus4;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (pc_q <= LAST_FETCH) begin
                    pc_d     = pc_plus4;
                    valid_d  = 1'b1;
                    instr_d  = bus.imem_data;
                    id_pc_d  = pc_q;
                    id_pc4_d = pc_plus4;
                    count_d  = count_q + 32'd1;
                end else begin
                    // Out-of-range fetch: park on the offending pc until redirected.
                    range_d = 1'b1;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = HALT;
                end
            end
            HALT: begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
                if (bus.redirect_valid) begin
                    pc_d       = redirect_pc;
                    misalign_d = misalign_q | redirect_misaligned;
                    state_d    = RUN;
                end
            end
            default: state_d = BOOT;
        endcase

        halted_d = (state_d == HALT);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            misalign_q <= 1'b0;
            range_q    <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            misalign_q <= misalign_d;
            range_q    <= range_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    assign bus.imem_addr      = pc_q;
    assign bus.if_id_valid    = valid_q;
    assign bus.if_id_instr    = instr_q;
    assign bus.if_id_pc       = id_pc_q;
    assign bus.if_id_pc_plus4 = id_pc4_q;
    assign bus.misalign_fault = misalign_q;
    assign bus.range_fault    = range_q;
    assign bus.halted         = halted_q;
    assign bus.fetch_count    = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot, stall, redirect, misalign,
// range halt, pc wrap and asynchronous reset, against a 512-byte memory model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] mem [0:127];

    instr_fetch_if bus ();

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (512),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = (bus.imem_addr < 32'd512) ? mem[bus.imem_addr[8:2]] : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"},  bus.imem_addr, 32'h0);
        check({tag, "_valid"}, 32'(bus.if_id_valid), 32'h0);
        check({tag, "_instr"}, bus.if_id_instr, NOP);
        check({tag, "_pc"},    bus.if_id_pc, 32'h0);
        check({tag, "_pc4"},   bus.if_id_pc_plus4, 32'h0);
        check({tag, "_mis"},   32'(bus.misalign_fault), 32'h0);
        check({tag, "_rng"},   32'(bus.range_fault), 32'h0);
        check({tag, "_halt"},  32'(bus.halted), 32'h0);
        check({tag, "_cnt"},   bus.fetch_count, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h00a0_0113;

        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 32'h0;
        #12;
        check_reset_state("rst");

        // Release between edges; first edge is BOOT.
        tick();
        rst_n = 1'b1;
        tick();
        check("boot_valid", 32'(bus.if_id_valid), 32'h0);
        check("boot_addr", bus.imem_addr, 32'h0);
        tick();
        check("f0_pc", bus.if_id_pc, 32'h0);
        check("f0_instr", bus.if_id_instr, 32'h0050_0093);
        check("f0_valid", 32'(bus.if_id_valid), 32'h1);
        check("f0_pc4", bus.if_id_pc_plus4, 32'h4);
        tick();
        check("f1_pc", bus.if_id_pc, 32'h4);
        check("f1_instr", bus.if_id_instr, 32'h00a0_0113);
        check("f1_cnt", bus.fetch_count, 32'd2);
        check("f1_addr", bus.imem_addr, 32'h8);

        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr", bus.imem_addr, 32'h8);
            check("stall_pc", bus.if_id_pc, 32'h4);
            check("stall_instr", bus.if_id_instr, 32'h00a0_0113);
            check("stall_cnt", bus.fetch_count, 32'd2);
        end
        bus.stall = 1'b0;
        tick();
        check("post_stall_pc", bus.if_id_pc, 32'h8);
        check("post_stall_instr", bus.if_id_instr, 32'hA000_0002);
        tick();
        check("f3_pc", bus.if_id_pc, 32'hC);
        check("f3_addr", bus.imem_addr, 32'h10);
        check("f3_cnt", bus.fetch_count, 32'd4);

        // Redirect beats stall.
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h40;
        bus.stall = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b0;
        check("redir_addr", bus.imem_addr, 32'h40);
        check("redir_valid", 32'(bus.if_id_valid), 32'h0);
        check("redir_instr", bus.if_id_instr, NOP);
        check("redir_mis", 32'(bus.misalign_fault), 32'h0);
        tick();
        check("redir_cap_pc", bus.if_id_pc, 32'h40);
        check("redir_cap_instr", bus.if_id_instr, 32'hA000_0010);
        check("redir_cap_cnt", bus.fetch_count, 32'd5);

        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_valid", 32'(bus.if_id_valid), 32'h0);
        check("flush_addr", bus.imem_addr, 32'h48);
        check("flush_cnt", bus.fetch_count, 32'd5);

        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h46;
        tick();
        bus.redirect_valid = 1'b0;
        check("mis_addr", bus.imem_addr, 32'h44);
        check("mis_flag", 32'(bus.misalign_fault), 32'h1);
        tick();
        check("mis_cap_pc", bus.if_id_pc, 32'h44);
        check("mis_sticky", 32'(bus.misalign_fault), 32'h1);

        // Run off the end of memory.
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h1F8;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        check("end504_pc", bus.if_id_pc, 32'h1F8);
        tick();
        check("end508_pc", bus.if_id_pc, 32'h1FC);
        check("end508_valid", 32'(bus.if_id_valid), 32'h1);
        check("end508_instr", bus.if_id_instr, 32'hA000_007F);
        check("end508_pc4", bus.if_id_pc_plus4, 32'h200);
        check("end508_halt", 32'(bus.halted), 32'h0);
        tick();
        check("range_flag", 32'(bus.range_fault), 32'h1);
        check("range_halt", 32'(bus.halted), 32'h1);
        check("range_addr", bus.imem_addr, 32'h200);
        check("range_valid", 32'(bus.if_id_valid), 32'h0);
        check("range_cnt", bus.fetch_count, 32'd8);
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        check("halt_hold_addr", bus.imem_addr, 32'h200);
        check("halt_hold", 32'(bus.halted), 32'h1);

        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'h0;
        tick();
        bus.redirect_valid = 1'b0;
        check("unhalt", 32'(bus.halted), 32'h0);
        check("unhalt_addr", bus.imem_addr, 32'h0);
        check("unhalt_rng", 32'(bus.range_fault), 32'h1);
        tick();
        check("unhalt_cap", bus.if_id_instr, 32'h0050_0093);
        check("unhalt_cnt", bus.fetch_count, 32'd9);

        // pc+4 wraps at the top of the address space.
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("wrap_next", bus.imem_addr, 32'h0);
        check("wrap_halt", 32'(bus.halted), 32'h0);
        tick();
        check("wrap_cap_pc", bus.if_id_pc, 32'h0);
        check("wrap_cnt", bus.fetch_count, 32'd10);

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("arst");
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_boot_valid", 32'(bus.if_id_valid), 32'h0);
        tick();
        check("arst_cap_pc", bus.if_id_pc, 32'h0);
        check("arst_cnt", bus.fetch_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
